// File: rtl/axi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axi_bus_arbiter
// Brief   : Shares one AXI master port between inst-read, data-read and
//           data-write clients; one outstanding read and one outstanding write.
// Revision: 1.0 - initial release
// ============================================================================
module axi_bus_arbiter #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    // read clients (bit0 = inst, bit1 = data)
    input  logic [1:0]                    rd_req,
    input  logic [2*ADDR_WIDTH-1:0]       rd_addr,
    input  logic [15:0]                   rd_len,
    input  logic [5:0]                    rd_size,
    output logic [1:0]                    rd_ack,
    output logic [1:0]                    rd_rvalid,
    output logic [AXI_DATA_WIDTH-1:0]     rd_rdata,
    output logic                          rd_rlast,
    // write client
    input  logic                          wr_req,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [7:0]                    wr_len,
    input  logic [2:0]                    wr_size,
    output logic                          wr_ack,
    input  logic                          wr_wvalid,
    input  logic [AXI_DATA_WIDTH-1:0]     wr_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   wr_wstrb,
    output logic                          wr_wready,
    output logic                          wr_done,
    // AXI read address / data
    output logic [3:0]                    arid,
    output logic [ADDR_WIDTH-1:0]         araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [3:0]                    rid,
    input  logic [AXI_DATA_WIDTH-1:0]     rdata,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready,
    // AXI write address / data / response
    output logic [ADDR_WIDTH-1:0]         awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [AXI_DATA_WIDTH-1:0]     wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic                          bvalid,
    output logic                          bready
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    rd_state_t r_rd_state, w_rd_state_nxt;
    wr_state_t r_wr_state, w_wr_state_nxt;

    logic       r_grant;
    logic       r_rr;
    logic [7:0] r_cnt;
    logic [1:0] w_elig;
    logic       w_pick;
    logic       w_wbeat;
    logic       w_unused;

    // Only one read is ever outstanding, so the returned ID carries no information.
    assign w_unused = ^rid;

    // Data reads wait behind any in-flight write to keep load/store ordering.
    assign w_elig  = {rd_req[1] && (r_wr_state == W_IDLE), rd_req[0]};
    assign w_pick  = (&w_elig) ? r_rr : w_elig[1];
    assign w_wbeat = (r_wr_state == W_DATA) && wr_wvalid && wready;

    // ------------------------------------------------------------------ read
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (|w_elig)          w_rd_state_nxt = R_AR;
            R_AR:    if (arready)          w_rd_state_nxt = R_DATA;
            R_DATA:  if (rvalid && rlast)  w_rd_state_nxt = R_IDLE;
            default:                       w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_state <= R_IDLE;
            r_grant    <= 1'b0;
            r_rr       <= 1'b0;
            arid       <= '0;
            araddr     <= '0;
            arlen      <= '0;
            arsize     <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if ((r_rd_state == R_IDLE) && (|w_elig)) begin
                r_grant <= w_pick;
                arid    <= {3'b000, w_pick};
                araddr  <= w_pick ? rd_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : rd_addr[ADDR_WIDTH-1:0];
                arlen   <= w_pick ? rd_len[15:8]  : rd_len[7:0];
                arsize  <= w_pick ? rd_size[5:3]  : rd_size[2:0];
            end
            if ((r_rd_state == R_DATA) && rvalid && rlast)
                r_rr <= ~r_grant;
        end
    end

    always_comb begin
        arvalid   = (r_rd_state == R_AR);
        rready    = (r_rd_state == R_DATA);
        rd_ack    = 2'b00;
        rd_rvalid = 2'b00;
        rd_rdata  = rdata;
        rd_rlast  = rlast;
        if ((r_rd_state == R_AR) && arready)
            rd_ack[r_grant] = 1'b1;
        if (r_rd_state == R_DATA)
            rd_rvalid[r_grant] = rvalid;
    end

    // ----------------------------------------------------------------- write
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (wr_req)                      w_wr_state_nxt = W_AW;
            W_AW:    if (awready)                     w_wr_state_nxt = W_DATA;
            W_DATA:  if (w_wbeat && (r_cnt == awlen)) w_wr_state_nxt = W_RESP;
            W_RESP:  if (bvalid)                      w_wr_state_nxt = W_IDLE;
            default:                                  w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_state <= W_IDLE;
            r_cnt      <= '0;
            awaddr     <= '0;
            awlen      <= '0;
            awsize     <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if ((r_wr_state == W_IDLE) && wr_req) begin
                awaddr <= wr_addr;
                awlen  <= wr_len;
                awsize <= wr_size;
                r_cnt  <= '0;
            end else if (w_wbeat) begin
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

    // W beats are only exposed once the address phase has completed.
    always_comb begin
        awvalid   = (r_wr_state == W_AW);
        wr_ack    = (r_wr_state == W_AW) && awready;
        wvalid    = (r_wr_state == W_DATA) && wr_wvalid;
        wr_wready = (r_wr_state == W_DATA) && wready;
        wlast     = (r_wr_state == W_DATA) && (r_cnt == awlen);
        wdata     = wr_wdata;
        wstrb     = wr_wstrb;
        bready    = (r_wr_state == W_RESP);
        wr_done   = (r_wr_state == W_RESP) && bvalid;
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_bus_arbiter
// Brief   : Directed self-checking bench for axi_bus_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_bus_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic            aclk, aresetn;
    logic [1:0]      rd_req, rd_ack, rd_rvalid;
    logic [2*AW-1:0] rd_addr;
    logic [15:0]     rd_len;
    logic [5:0]      rd_size;
    logic [DW-1:0]   rd_rdata;
    logic            rd_rlast;
    logic            wr_req, wr_ack, wr_wvalid, wr_wready, wr_done;
    logic [AW-1:0]   wr_addr;
    logic [7:0]      wr_len;
    logic [2:0]      wr_size;
    logic [DW-1:0]   wr_wdata;
    logic [DW/8-1:0] wr_wstrb;
    logic [3:0]      arid, rid;
    logic [AW-1:0]   araddr, awaddr;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, awsize;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]   rdata, wdata;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DW/8-1:0] wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    axi_bus_arbiter #(.AXI_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_size(rd_size),
        .rd_ack(rd_ack), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .rd_rlast(rd_rlast),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_size(wr_size),
        .wr_ack(wr_ack), .wr_wvalid(wr_wvalid), .wr_wdata(wr_wdata), .wr_wstrb(wr_wstrb),
        .wr_wready(wr_wready), .wr_done(wr_done),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    // Entered while the read FSM is idle and the request is already driven.
    task automatic read_txn(input int g, input logic [31:0] addr, input logic [7:0] len,
                            input int beats, input int ar_wait, input logic [1:0] req_after);
        logic [31:0] exp_d;
        tick();
        for (int k = 0; k < ar_wait; k++) begin
            check("ar_hold_valid", arvalid, 1);
            check("ar_hold_addr", araddr, addr);
            check("ar_hold_noack", rd_ack, 0);
            tick();
        end
        check("ar_valid", arvalid, 1);
        check("ar_id", arid, g);
        check("ar_addr", araddr, addr);
        check("ar_len", arlen, len);
        check("ar_size", arsize, 2);
        arready = 1'b1;
        #1;
        check("rd_ack", rd_ack, 64'd1 << g);
        tick();
        arready = 1'b0;
        rd_req  = req_after;
        #1;
        check("ar_dropped", arvalid, 0);
        check("rready_on", rready, 1);
        for (int i = 0; i < beats; i++) begin
            exp_d  = 32'hD000_0000 + g * 256 + i;
            rvalid = 1'b1;
            rdata  = exp_d;
            rlast  = (i == beats - 1);
            #1;
            check("r_route", rd_rvalid, 64'd1 << g);
            check("r_data", rd_rdata, exp_d);
            check("r_last", rd_rlast, (i == beats - 1));
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = '0;
    endtask

    task automatic write_start(input logic [31:0] addr, input logic [7:0] len);
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_len  = len;
        wr_size = 3'd2;
        #1;
        check("aw_not_yet", awvalid, 0);
        tick();
        check("aw_valid", awvalid, 1);
        check("aw_addr", awaddr, addr);
        check("aw_len", awlen, len);
        check("wr_ack_wait", wr_ack, 0);
        wr_wvalid = 1'b1;
        #1;
        check("no_w_before_aw", wvalid, 0);
        awready = 1'b1;
        #1;
        check("wr_ack", wr_ack, 1);
        tick();
        awready   = 1'b0;
        wr_req    = 1'b0;
        wr_wvalid = 1'b0;
    endtask

    task automatic write_beats(input int n, input bit toggle);
        int beats = 0;
        for (int cyc = 0; cyc < 4 * n + 4 && beats < n; cyc++) begin
            wr_wvalid = 1'b1;
            wr_wdata  = 32'h100 + beats;
            wr_wstrb  = 4'hA;
            wready    = toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            check("w_valid", wvalid, 1);
            check("w_data", {wstrb, wdata}, {4'hA, 32'h100 + beats});
            check("w_last", wlast, (beats == n - 1));
            check("w_wready", wr_wready, wready);
            if (wready) beats++;
            tick();
        end
        wr_wvalid = 1'b0;
        wready    = 1'b0;
        check("w_beats", beats, n);
    endtask

    task automatic write_resp();
        #1;
        check("b_ready", bready, 1);
        check("done_early", wr_done, 0);
        tick();
        bvalid = 1'b1;
        #1;
        check("wr_done", wr_done, 1);
        tick();
        bvalid = 1'b0;
        #1;
        check("b_ready_off", bready, 0);
        check("done_once", wr_done, 0);
    endtask

    initial begin
        aresetn = 1'b0;
        rd_req = '0; rd_addr = '0; rd_len = '0; rd_size = 6'b010_010;
        wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_size = '0;
        wr_wvalid = 1'b0; wr_wdata = '0; wr_wstrb = '0;
        arready = 1'b0; rid = 4'h5; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        tick();
        tick();
        check("rst_ctrl", {arvalid, awvalid, wvalid, rready, bready, rd_ack, wr_ack, wr_done, rd_rvalid}, 0);
        check("rst_ar", {arid, araddr, arlen, arsize}, 0);
        check("rst_aw", {awaddr, awlen, awsize}, 0);
        aresetn = 1'b1;
        tick();

        // Inst read alone, 4 beats
        rd_addr = {32'h8000_0040, 32'h1C00_0000};
        rd_len  = {8'd0, 8'd3};
        rd_req  = 2'b01;
        #1;
        check("ar_1cyc_late", arvalid, 0);
        read_txn(0, 32'h1C00_0000, 8'd3, 4, 0, 2'b00);
        check("rd_idle", rready, 0);

        // Both read clients, fresh after reset: 0,1,0,1
        do_reset();
        rd_len = 16'h0000;
        rd_req = 2'b11;
        read_txn(0, 32'h1C00_0000, 8'd0, 1, 0, 2'b11);
        read_txn(1, 32'h8000_0040, 8'd0, 1, 0, 2'b11);
        read_txn(0, 32'h1C00_0000, 8'd0, 1, 0, 2'b11);
        read_txn(1, 32'h8000_0040, 8'd0, 1, 0, 2'b00);

        // Write len 7 with wready toggling
        write_start(32'h0000_1000, 8'd7);
        write_beats(8, 1'b1);
        write_resp();

        // Data read blocked during write, inst read passes
        write_start(32'h0000_2000, 8'd0);
        rd_addr = {32'h8000_0100, 32'h1C00_0100};
        rd_req  = 2'b10;
        tick();
        check("data_blocked_a", arvalid, 0);
        tick();
        check("data_blocked_b", arvalid, 0);
        rd_req = 2'b11;
        read_txn(0, 32'h1C00_0100, 8'd0, 1, 0, 2'b10);
        check("data_blocked_c", arvalid, 0);
        tick();
        check("data_blocked_d", arvalid, 0);
        write_beats(1, 1'b0);
        write_resp();
        check("data_blocked_done", arvalid, 0);
        read_txn(1, 32'h8000_0100, 8'd0, 1, 0, 2'b00);

        // arready held low for 5 cycles
        rd_addr = {32'h8000_0200, 32'h1C00_0200};
        rd_len  = {8'd1, 8'd0};
        rd_req  = 2'b10;
        read_txn(1, 32'h8000_0200, 8'd1, 2, 5, 2'b00);

        // Async reset during data phases
        write_start(32'h0000_3000, 8'd3);
        wr_wvalid = 1'b1;
        rd_addr = {32'h8000_0300, 32'h1C00_0300};
        rd_len  = 16'h0000;
        rd_req  = 2'b01;
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rd_req  = 2'b00;
        #1;
        check("mid_rready", rready, 1);
        check("mid_wvalid", wvalid, 1);
        aresetn = 1'b0;
        #1;
        check("arst_data", {arvalid, awvalid, wvalid, rready, bready}, 0);
        check("arst_araddr", araddr, 0);
        tick();
        aresetn   = 1'b1;
        wr_wvalid = 1'b0;

        // Async reset during address phases
        rd_req  = 2'b01;
        wr_req  = 1'b1;
        wr_addr = 32'h0000_4000;
        tick();
        check("mid_addr_valids", {arvalid, awvalid}, 2'b11);
        aresetn = 1'b0;
        #1;
        check("arst_addr", {arvalid, awvalid, awaddr}, 0);
        tick();
        aresetn = 1'b1;
        wr_req  = 1'b0;

        // Fresh transactions after reset
        read_txn(0, 32'h1C00_0300, 8'd0, 1, 0, 2'b00);
        write_start(32'h0000_5000, 8'd1);
        write_beats(2, 1'b0);
        write_resp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
